crc_arb: RTL and testbench

CRC_ARB -- requirements
Module: crc_arb

---
 rtl/crc_arb_if.sv | 26 ++
 rtl/crc_arb.sv | 173 +++++++++++++++++
 tb/tb_crc_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_arb_if.sv
// Channel-side and result-side handshake bundle for crc_arb.
// The arbiter uses the slave modport; the traffic source/result sink uses master.
interface crc_arb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CRC_WIDTH  = 32,
   parameter int NUM_CH     = 4
);
   logic [NUM_CH-1:0]            s_valid;
   logic [NUM_CH-1:0]            s_ready;
   logic [NUM_CH*DATA_WIDTH-1:0] s_data;
   logic [NUM_CH-1:0]            s_last;
   logic                         res_valid;
   logic                         res_ready;
   logic [$clog2(NUM_CH)-1:0]    res_ch;
   logic [CRC_WIDTH-1:0]         res_crc;

   modport master (
      output s_valid, s_data, s_last, res_ready,
      input  s_ready, res_valid, res_ch, res_crc
   );

   modport slave (
      input  s_valid, s_data, s_last, res_ready,
      output s_ready, res_valid, res_ch, res_crc
   );
endinterface

// File: rtl/crc_arb.sv
// Round-robin arbiter that streams whole frames from NUM_CH channels into one shared
// CRC engine, loading each channel's own CRC profile and returning one result per frame.
module crc_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int CRC_WIDTH  = 32,
   parameter int NUM_CH     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   crc_arb_if.slave                  bus,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [CRC_WIDTH:0]        cfg_poly,
   input  logic [CRC_WIDTH-1:0]      cfg_init,
   input  logic [CRC_WIDTH-1:0]      cfg_xorout,
   input  logic                      cfg_data_rev,
   input  logic                      cfg_crc_rev,
   output logic                      crc_clear,
   output logic [CRC_WIDTH-1:0]      crc_init,
   output logic [CRC_WIDTH:0]        crc_poly,
   output logic                      crc_data_rev,
   output logic                      crc_crc_rev,
   output logic [CRC_WIDTH-1:0]      crc_xorout,
   output logic [DATA_WIDTH-1:0]     crc_data,
   output logic                      crc_data_valid,
   input  logic [CRC_WIDTH-1:0]      crc_result
);
   localparam int CH_W = $clog2(NUM_CH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CLEAR  = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;
   localparam logic [1:0] ST_RESULT = 2'd3;

   function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int off);
      return CH_W'((int'(base) + off) % NUM_CH);
   endfunction

   logic [1:0]           r_state;
   logic [CH_W-1:0]      r_rr_ptr;
   logic [CH_W-1:0]      r_grant;

   logic [CRC_WIDTH:0]   r_prof_poly   [NUM_CH];
   logic [CRC_WIDTH-1:0] r_prof_init   [NUM_CH];
   logic [CRC_WIDTH-1:0] r_prof_xorout [NUM_CH];
   logic [NUM_CH-1:0]    r_prof_data_rev;
   logic [NUM_CH-1:0]    r_prof_crc_rev;

   logic [CRC_WIDTH:0]   r_act_poly;
   logic [CRC_WIDTH-1:0] r_act_init;
   logic [CRC_WIDTH-1:0] r_act_xorout;
   logic                 r_act_data_rev;
   logic                 r_act_crc_rev;

   logic                  w_found;
   logic [CH_W-1:0]       w_pick;
   logic                  w_cfg_hit;
   logic                  w_beat_valid;
   logic                  w_beat_last;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_beat_data;

   // Round-robin pick: scan from the far end so the lowest offset from r_rr_ptr wins
   always_comb begin
      w_found = |bus.s_valid;
      w_pick  = r_rr_ptr;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         w_pick = bus.s_valid[rr_index(r_rr_ptr, i)] ? rr_index(r_rr_ptr, i) : w_pick;
      end
   end

   assign w_cfg_hit    = cfg_we && (int'(cfg_ch) < NUM_CH);
   assign w_beat_valid = bus.s_valid[r_grant];
   assign w_beat_last  = bus.s_last[r_grant];
   assign w_beat_data  = bus.s_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
   assign w_accept     = (r_state == ST_DATA) && w_beat_valid;

   // Per-channel profile storage; writes land here and reach the engine only on a grant
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < NUM_CH; n++) begin
            r_prof_poly[n]   <= '0;
            r_prof_init[n]   <= '0;
            r_prof_xorout[n] <= '0;
         end
         r_prof_data_rev <= '0;
         r_prof_crc_rev  <= '0;
      end else if (w_cfg_hit) begin
         r_prof_poly[cfg_ch]     <= cfg_poly;
         r_prof_init[cfg_ch]     <= cfg_init;
         r_prof_xorout[cfg_ch]   <= cfg_xorout;
         r_prof_data_rev[cfg_ch] <= cfg_data_rev;
         r_prof_crc_rev[cfg_ch]  <= cfg_crc_rev;
      end
   end

   // Frame sequencer: grant, clear engine, stream beats, hold result until taken
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_rr_ptr       <= '0;
         r_grant        <= '0;
         r_act_poly     <= '0;
         r_act_init     <= '0;
         r_act_xorout   <= '0;
         r_act_data_rev <= 1'b0;
         r_act_crc_rev  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant        <= w_pick;
                  r_act_poly     <= r_prof_poly[w_pick];
                  r_act_init     <= r_prof_init[w_pick];
                  r_act_xorout   <= r_prof_xorout[w_pick];
                  r_act_data_rev <= r_prof_data_rev[w_pick];
                  r_act_crc_rev  <= r_prof_crc_rev[w_pick];
                  r_state        <= ST_CLEAR;
               end
            end
            ST_CLEAR: r_state <= ST_DATA;
            ST_DATA: begin
               if (w_accept && w_beat_last) begin
                  r_state <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (bus.res_ready) begin
                  r_rr_ptr <= rr_index(r_grant, 1);
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // State-decoded handshake and engine strobes
   always_comb begin
      bus.s_ready    = '0;
      bus.res_valid  = 1'b0;
      bus.res_ch     = '0;
      crc_clear      = 1'b0;
      crc_data_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.s_ready = '0;
         end
         ST_CLEAR: begin
            crc_clear = 1'b1;
         end
         ST_DATA: begin
            bus.s_ready    = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;
            crc_data_valid = w_beat_valid;
         end
         ST_RESULT: begin
            bus.res_valid = 1'b1;
            bus.res_ch    = r_grant;
         end
         default: begin
            bus.s_ready = '0;
         end
      endcase
   end

   assign bus.res_crc  = crc_result;
   assign crc_data     = w_beat_data;
   assign crc_init     = r_act_init;
   assign crc_poly     = r_act_poly;
   assign crc_xorout   = r_act_xorout;
   assign crc_data_rev = r_act_data_rev;
   assign crc_crc_rev  = r_act_crc_rev;
endmodule

// File: tb/tb_crc_arb.sv
// Bench for crc_arb with a behavioural CRC engine attached; results are checked
// against a scoreboard filled as frames are launched.
module tb_crc_arb;
   localparam int DW = 8;
   localparam int CW = 32;
   localparam int NC = 4;
   localparam int BUDGET = 300;
   localparam logic [32:0] P32 = 33'h104C11DB7;

   typedef logic [7:0] bq_t [$];
   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] crc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   crc_arb_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .NUM_CH(NC)) bus ();

   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [32:0] cfg_poly;
   logic [31:0] cfg_init, cfg_xorout;
   logic        cfg_data_rev, cfg_crc_rev;
   logic        crc_clear, crc_data_rev, crc_crc_rev, crc_data_valid;
   logic [31:0] crc_init, crc_xorout, crc_result;
   logic [32:0] crc_poly;
   logic [7:0]  crc_data;

   logic       tb_valid [NC];
   logic [7:0] tb_data  [NC];
   logic       tb_last  [NC];

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   crc_arb #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .NUM_CH(NC)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_poly(cfg_poly), .cfg_init(cfg_init),
      .cfg_xorout(cfg_xorout), .cfg_data_rev(cfg_data_rev), .cfg_crc_rev(cfg_crc_rev),
      .crc_clear(crc_clear), .crc_init(crc_init), .crc_poly(crc_poly),
      .crc_data_rev(crc_data_rev), .crc_crc_rev(crc_crc_rev), .crc_xorout(crc_xorout),
      .crc_data(crc_data), .crc_data_valid(crc_data_valid), .crc_result(crc_result)
   );

   always_comb begin
      for (int c = 0; c < NC; c++) begin
         bus.s_valid[c]          = tb_valid[c];
         bus.s_data[c*DW +: DW]  = tb_data[c];
         bus.s_last[c]           = tb_last[c];
      end
   end

   function automatic logic [31:0] refl32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   function automatic logic [31:0] eng_step(input logic [31:0] c, input logic [7:0] d,
                                            input logic [31:0] p, input logic drev);
      logic [31:0] r;
      logic        b;
      r = c;
      for (int i = 0; i < 8; i++) begin
         b = drev ? d[i] : d[7-i];
         r = (r[31] ^ b) ? ((r << 1) ^ p) : (r << 1);
      end
      return r;
   endfunction

   // Table-free reflected CRC reference (shift-right form)
   function automatic logic [31:0] ref_crc_refl(input bq_t m, input logic [31:0] poly,
                                                input logic [31:0] init, input logic [31:0] xo);
      logic [31:0] rp;
      logic [31:0] r;
      rp = refl32(poly);
      r  = refl32(init);
      foreach (m[k]) begin
         r = r ^ {24'h0, m[k]};
         for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ rp) : (r >> 1);
      end
      return r ^ xo;
   endfunction

   // Behavioural CRC engine: registered state, output post-processing from active profile
   logic [31:0] eng_crc;
   always_ff @(posedge clk) begin
      if (reset) eng_crc <= 32'h0;
      else if (crc_clear) eng_crc <= crc_init;
      else if (crc_data_valid) eng_crc <= eng_step(eng_crc, crc_data, crc_poly[31:0], crc_data_rev);
   end
   always_comb crc_result = (crc_crc_rev ? refl32(eng_crc) : eng_crc) ^ crc_xorout;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.res_valid && bus.res_ready) begin
         if (sb.size() == 0) begin
            check_val("unexpected_result", {62'h0, bus.res_ch}, 64'hFFFF);
         end else begin
            e = sb.pop_front();
            check_val("res_ch", bus.res_ch, e.ch);
            check_val("res_crc", bus.res_crc, e.crc);
         end
      end
   end

   task automatic cfg_write(input logic [1:0] ch, input logic [32:0] p, input logic [31:0] ini,
                            input logic [31:0] xo, input logic dr, input logic cr);
      cfg_we = 1'b1; cfg_ch = ch; cfg_poly = p; cfg_init = ini; cfg_xorout = xo;
      cfg_data_rev = dr; cfg_crc_rev = cr;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic send_frame(input int ch, input bq_t m, input int gap, output int first_wait);
      int w;
      first_wait = -1;
      for (int i = 0; i < m.size(); i++) begin
         if (gap > 0 && i > 0 && (i % 3) == 0) begin
            tb_valid[ch] = 1'b0;
            tb_last[ch]  = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         tb_valid[ch] = 1'b1;
         tb_data[ch]  = m[i];
         tb_last[ch]  = (i == m.size() - 1);
         w = 0;
         @(negedge clk);
         while (!bus.s_ready[ch] && w < BUDGET) begin
            w++;
            @(negedge clk);
         end
         if (w >= BUDGET) begin
            check_val("accept_timeout", {63'h0, bus.s_ready[ch]}, 64'h1);
            tb_valid[ch] = 1'b0;
            return;
         end
         if (i == 0) first_wait = w;
         @(posedge clk); #1;
      end
      tb_valid[ch] = 1'b0;
      tb_last[ch]  = 1'b0;
      check_val("res_latency", {63'h0, bus.res_valid}, 64'h1);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < BUDGET) begin
         @(negedge clk);
         w++;
      end
      check_val("drain", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bq_t msg;
      int  fw, fw3;
      logic [31:0] crc_init0;
      for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
      crc_init0 = ref_crc_refl(msg, 32'h04C11DB7, 32'h0, 32'hFFFFFFFF);
      for (int c = 0; c < NC; c++) begin
         tb_valid[c] = 1'b0; tb_data[c] = 8'h00; tb_last[c] = 1'b0;
      end
      reset = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_poly = 33'h0; cfg_init = 32'h0;
      cfg_xorout = 32'h0; cfg_data_rev = 1'b0; cfg_crc_rev = 1'b0; bus.res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state in IDLE
      @(negedge clk);
      check_val("rst_s_ready", bus.s_ready, 0);
      check_val("rst_crc_clear", crc_clear, 0);
      check_val("rst_crc_dv", crc_data_valid, 0);
      check_val("rst_res_valid", bus.res_valid, 0);
      check_val("rst_res_ch", bus.res_ch, 0);
      check_val("rst_res_crc", bus.res_crc, 32'h0);
      check_val("rst_crc_poly", crc_poly, 33'h0);
      @(posedge clk); #1;

      // CRC-32 on ch1
      cfg_write(2'd1, P32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      sb.push_back('{2'd1, 32'hCBF43926});
      send_frame(1, msg, 0, fw);
      check_val("grant_latency", fw, 2);
      drain();

      // Profile rewrite mid-frame only affects the next grant
      sb.push_back('{2'd1, 32'hCBF43926});
      fork
         send_frame(1, msg, 0, fw);
         begin
            repeat (5) @(posedge clk);
            #1 cfg_write(2'd1, P32, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1);
         end
      join
      drain();
      sb.push_back('{2'd1, crc_init0});
      send_frame(1, msg, 0, fw);
      drain();

      // Result back-pressure with a competing request on ch3
      cfg_write(2'd3, P32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      bus.res_ready = 1'b0;
      sb.push_back('{2'd1, crc_init0});
      sb.push_back('{2'd3, 32'hFC891918});
      fork
         begin
            send_frame(1, msg, 0, fw);
            repeat (5) begin
               @(negedge clk);
               check_val("hold_res_valid", bus.res_valid, 1);
               check_val("hold_res_crc", bus.res_crc, crc_init0);
               check_val("hold_res_ch", bus.res_ch, 1);
               check_val("hold_s_ready", bus.s_ready, 0);
               check_val("hold_no_grant", crc_clear, 0);
            end
            @(posedge clk);
            #1 bus.res_ready = 1'b1;
         end
         begin
            @(posedge clk);
            #1 send_frame(3, msg, 0, fw3);
         end
      join
      drain();

      // Gaps inside a frame give the same result as the gap-free run
      sb.push_back('{2'd3, 32'hFC891918});
      send_frame(3, msg, 2, fw);
      drain();

      // Round-robin fairness from rr_ptr=0
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      cfg_write(2'd0, P32, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
      cfg_write(2'd2, P32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      sb.push_back('{2'd0, 32'h0376E6E7});
      sb.push_back('{2'd2, 32'hCBF43926});
      sb.push_back('{2'd0, 32'h0376E6E7});
      fork
         begin
            send_frame(0, msg, 0, fw);
            send_frame(0, msg, 0, fw);
         end
         send_frame(2, msg, 0, fw3);
      join
      drain();

      // Reset mid-frame abandons it and wipes profiles; cfg_we during reset is ignored
      tb_valid[0] = 1'b1; tb_data[0] = 8'hA5; tb_last[0] = 1'b0;
      fw = 0;
      @(negedge clk);
      while (!bus.s_ready[0] && fw < BUDGET) begin
         fw++;
         @(negedge clk);
      end
      check_val("mid_reset_in_data", bus.s_ready[0], 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_poly = P32; cfg_init = 32'hFFFFFFFF;
      cfg_xorout = 32'hFFFFFFFF; cfg_data_rev = 1'b1; cfg_crc_rev = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; cfg_we = 1'b0; tb_valid[0] = 1'b0;
      @(negedge clk);
      check_val("mid_reset_res_valid", bus.res_valid, 0);
      check_val("mid_reset_s_ready", bus.s_ready, 0);
      check_val("mid_reset_crc_poly", crc_poly, 33'h0);
      @(posedge clk); #1;
      sb.push_back('{2'd0, 32'h0});
      send_frame(0, msg, 0, fw);
      check_val("post_reset_grant_latency", fw, 2);
      drain();

      check_val("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
